serial_pattern_generator: RTL and testbench

Serial bit-pattern transmitter. It accepts a pattern word through a valid/ready handshake and shifts it out MSB-first, one bit per clock, with a qualifying valid flag. It is the stimulus-side counterpart of the shift-register sequence detectors in the FSM exercises. Its serial output feeds a detector's `new_bit` input directly, for example to emit "110011" for the 6-bit detector.

---
 rtl/serial_pattern_gen_pkg.sv | 15 +
 rtl/seq_gen_bit_counter.sv | 37 +++
 rtl/serial_pattern_generator.sv | 161 ++++++++++++++++
 tb/tb_serial_pattern_generator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_gen_pkg.sv
// Shared types and helpers for the serial pattern generator.
package serial_pattern_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } seq_gen_state_t;

  // Width of a length field able to hold 0..max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_gen_bit_counter.sv
// Loadable down-counter with a zero flag; serves as bit index and gap timer.
module seq_gen_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count_next,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_next = count_d;
  assign zero       = (count_q == '0);

endmodule

// File: rtl/serial_pattern_generator.sv
// Serial MSB-first pattern transmitter with valid/ready intake and optional
// post-transfer gap. Define SERIAL_PATTERN_GEN_REPEAT_EN to enable repeat_cnt.
//
// Handshake: a pattern is taken on a rising clk edge where pattern_valid and
// pattern_ready are both 1; pattern_ready depends only on registered state.
module serial_pattern_generator
  import serial_pattern_gen_pkg::*;
#(
  parameter int MAX_LEN    = 8,
  parameter int GAP_CYCLES = 0,
  parameter int REP_W      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pattern_valid,
  output logic                       pattern_ready,
  input  logic [MAX_LEN-1:0]         pattern,
  input  logic [len_w(MAX_LEN)-1:0]  pattern_len,
  input  logic [REP_W-1:0]           repeat_cnt,
  output logic                       out_bit,
  output logic                       out_valid,
  output logic                       done,
  output seq_gen_state_t             dbg_state
);

  localparam int LEN_W = len_w(MAX_LEN);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int CNT_W = (LEN_W > GAP_W) ? LEN_W : GAP_W;

  seq_gen_state_t     state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ready_q, ready_d;
  logic               out_bit_q, out_bit_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;

  logic [LEN_W-1:0]   eff_len;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_dec;
  logic [CNT_W-1:0]   cnt_next;
  logic               cnt_zero;
  logic               rep_more;
  logic               rep_last;

`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
  logic [REP_W-1:0]   rep_q, rep_d;
  assign rep_more = (rep_q != '0);
  assign rep_last = (rep_d == '0);
`else
  logic               unused_repeat_cnt;
  assign unused_repeat_cnt = ^repeat_cnt;
  assign rep_more = 1'b0;
  assign rep_last = 1'b1;
`endif

  assign eff_len = (pattern_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pattern_len;

  seq_gen_bit_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_val   (cnt_load_val),
    .dec        (cnt_dec),
    .count_next (cnt_next),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    len_d        = len_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
    rep_d        = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (pattern_valid) begin
          pat_d        = pattern;
          len_d        = eff_len;
          state_d      = SHIFT;
          cnt_load     = 1'b1;
          cnt_load_val = (eff_len == '0) ? '0 : CNT_W'(eff_len - LEN_W'(1));
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
          // An empty pattern has nothing to repeat.
          rep_d        = (eff_len == '0) ? '0 : repeat_cnt;
`endif
        end
      end
      SHIFT: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (rep_more) begin
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(len_q - LEN_W'(1));
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
          rep_d        = rep_q - REP_W'(1);
`endif
        end else if (GAP_CYCLES > 0) begin
          state_d      = GAP;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(GAP_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are precomputed from next-cycle state so they come straight off flops.
    ready_d     = (state_d == IDLE);
    out_valid_d = (state_d == SHIFT) && (len_d != '0);
    out_bit_d   = out_valid_d && pat_d[cnt_next[IDX_W-1:0]];
    done_d      = (state_d == SHIFT) && (cnt_next == '0) && rep_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ready_q     <= 1'b1;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      ready_q     <= ready_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign pattern_ready = ready_q;
  assign out_bit       = out_bit_q;
  assign out_valid     = out_valid_q;
  assign done          = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Directed bench for serial_pattern_generator: vector table plus gap and reset sequences.
module tb_serial_pattern_generator;
  import serial_pattern_gen_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = len_w(MAX_LEN);
  localparam int REP_W   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance a: GAP_CYCLES=0
  logic               a_valid, a_ready, a_bit, a_ov, a_done;
  logic [MAX_LEN-1:0] a_pattern;
  logic [LEN_W-1:0]   a_len;
  logic [REP_W-1:0]   a_rep;
  seq_gen_state_t     a_state;

  // Instance b: GAP_CYCLES=2
  logic               b_valid, b_ready, b_bit, b_ov, b_done;
  logic [MAX_LEN-1:0] b_pattern;
  logic [LEN_W-1:0]   b_len;
  logic [REP_W-1:0]   b_rep;
  seq_gen_state_t     b_state;

  serial_pattern_generator #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(0), .REP_W(REP_W)) dut_a (
    .clk(clk), .rst(rst), .pattern_valid(a_valid), .pattern_ready(a_ready),
    .pattern(a_pattern), .pattern_len(a_len), .repeat_cnt(a_rep),
    .out_bit(a_bit), .out_valid(a_ov), .done(a_done), .dbg_state(a_state)
  );

  serial_pattern_generator #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(2), .REP_W(REP_W)) dut_b (
    .clk(clk), .rst(rst), .pattern_valid(b_valid), .pattern_ready(b_ready),
    .pattern(b_pattern), .pattern_len(b_len), .repeat_cnt(b_rep),
    .out_bit(b_bit), .out_valid(b_ov), .done(b_done), .dbg_state(b_state)
  );

  // Stand-in for a 6-bit shift-register detector fed from instance a.
  logic [5:0] det_sr;
  always_ff @(posedge clk) begin
    if (rst) det_sr <= '0;
    else if (a_ov) det_sr <= {det_sr[4:0], a_bit};
  end

  typedef struct {
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [REP_W-1:0]   rep;
    logic [15:0]        exp_bits;
    int                 exp_n;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  int   n_vec = 0;
  int   n_err = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_ready(input string name);
    int guard = 0;
    while (!a_ready && guard < 20) begin
      step();
      guard++;
    end
    check(name, a_ready, 1);
  endtask

  task automatic run_vec(input int idx);
    vec_t v = vecs[idx];
    logic [0:0] e;
    wait_a_ready($sformatf("v%0d_ready_before", idx));
    a_pattern = v.pattern;
    a_len     = v.len;
    a_rep     = v.rep;
    a_valid   = 1'b1;
    for (int i = v.exp_n - 1; i >= 0; i--) exp_q.push_back(v.exp_bits[i]);
    step();
    a_valid = 1'b0;
    if (v.exp_n == 0) begin
      check($sformatf("v%0d_empty_valid", idx), a_ov, 0);
      check($sformatf("v%0d_empty_done", idx), a_done, 1);
      check($sformatf("v%0d_empty_ready", idx), a_ready, 0);
    end else begin
      for (int i = 0; i < v.exp_n; i++) begin
        e = exp_q.pop_front();
        check($sformatf("v%0d_b%0d_valid", idx, i), a_ov, 1);
        check($sformatf("v%0d_b%0d_bit", idx, i), a_bit, e);
        check($sformatf("v%0d_b%0d_done", idx, i), a_done, (i == v.exp_n - 1) ? 1 : 0);
        check($sformatf("v%0d_b%0d_ready", idx, i), a_ready, 0);
        if (i < v.exp_n - 1) step();
      end
    end
    step();
    check($sformatf("v%0d_after_valid", idx), a_ov, 0);
    check($sformatf("v%0d_after_bit", idx), a_bit, 0);
    check($sformatf("v%0d_after_done", idx), a_done, 0);
    check($sformatf("v%0d_after_ready", idx), a_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    logic [3:0] gap_exp1;
    logic [3:0] gap_exp2;

    vecs[0] = '{8'b0011_0011, 4'd6,  2'd0, 16'h0033, 6};
    vecs[1] = '{8'hA5,        4'd8,  2'd0, 16'h00A5, 8};
    vecs[2] = '{8'b1000_0001, 4'd12, 2'd0, 16'h0081, 8};
    vecs[3] = '{8'hF0,        4'd1,  2'd0, 16'h0000, 1};
    vecs[4] = '{8'b1111_0110, 4'd3,  2'd0, 16'h0006, 3};
    vecs[5] = '{8'hFF,        4'd0,  2'd0, 16'h0000, 0};
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
    vecs[6] = '{8'b0000_1010, 4'd4,  2'd2, 16'h0AAA, 12};
    vecs[7] = '{8'b0000_0001, 4'd2,  2'd1, 16'h0005, 4};
    vecs[8] = '{8'h01,        4'd1,  2'd3, 16'h000F, 4};
`else
    vecs[6] = '{8'b0000_1010, 4'd4,  2'd2, 16'h000A, 4};
    vecs[7] = '{8'b0000_0001, 4'd2,  2'd1, 16'h0001, 2};
    vecs[8] = '{8'h01,        4'd1,  2'd3, 16'h0001, 1};
`endif

    rst = 1'b1;
    a_valid = 1'b0; a_pattern = '0; a_len = '0; a_rep = '0;
    b_valid = 1'b0; b_pattern = '0; b_len = '0; b_rep = '0;
    repeat (3) step();
    rst = 1'b0;

    check("rst_a_ready", a_ready, 1);
    check("rst_a_valid", a_ov, 0);
    check("rst_a_bit", a_bit, 0);
    check("rst_a_done", a_done, 0);
    check("rst_a_state", a_state, IDLE);
    check("rst_b_ready", b_ready, 1);
    check("rst_b_valid", b_ov, 0);
    step();
    check("idle_a_ready", a_ready, 1);

    for (int v = 0; v < NV; v++) begin
      run_vec(v);
      if (v == 0) check("detector_110011", det_sr, 6'b110011);
    end

    // Gap sequence on instance b: valid held high across two transfers.
    gap_exp1 = 4'b1010;
    gap_exp2 = 4'b0110;
    check("gap_ready_T", b_ready, 1);
    b_pattern = 8'b0000_1010;
    b_len     = 4'd4;
    b_valid   = 1'b1;
    step();
    b_pattern = 8'b0000_0110;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("gap_p1_b%0d_valid", i), b_ov, 1);
      check($sformatf("gap_p1_b%0d_bit", i), b_bit, gap_exp1[3-i]);
      check($sformatf("gap_p1_b%0d_done", i), b_done, (i == 3) ? 1 : 0);
      check($sformatf("gap_p1_b%0d_ready", i), b_ready, 0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("gap_c%0d_ready", i), b_ready, 0);
      check($sformatf("gap_c%0d_valid", i), b_ov, 0);
      check($sformatf("gap_c%0d_bit", i), b_bit, 0);
      check($sformatf("gap_c%0d_state", i), b_state, GAP);
      step();
    end
    check("gap_idle_ready", b_ready, 1);
    check("gap_idle_valid", b_ov, 0);
    step();
    b_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("gap_p2_b%0d_valid", i), b_ov, 1);
      check($sformatf("gap_p2_b%0d_bit", i), b_bit, gap_exp2[3-i]);
      check($sformatf("gap_p2_b%0d_done", i), b_done, (i == 3) ? 1 : 0);
      step();
    end
    check("gap_p2_after_ready", b_ready, 0);
    check("gap_p2_after_valid", b_ov, 0);
    repeat (3) step();
    check("gap_p2_back_ready", b_ready, 1);

    // Reset during the 3rd bit of a 6-bit transfer on instance a.
    wait_a_ready("rstmid_ready_before");
    a_pattern = 8'b0011_0011;
    a_len     = 4'd6;
    a_rep     = 2'd0;
    a_valid   = 1'b1;
    step();
    a_valid = 1'b0;
    check("rstmid_bit1", a_bit, 1);
    step();
    step();
    check("rstmid_bit3_valid", a_ov, 1);
    check("rstmid_bit3", a_bit, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_valid", a_ov, 0);
    check("rstmid_done", a_done, 0);
    check("rstmid_ready", a_ready, 1);
    check("rstmid_bit", a_bit, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_done || a_ov) done_seen++;
      step();
    end
    check("rstmid_no_done", done_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
